mod_exp: RTL and testbench

MOD_EXP -- requirements
Module: mod_exp

---
 rtl/mod_exp.sv | 187 ++++++++++++++++++
 tb/tb_mod_exp.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mod_exp.sv
// Iterative modular exponentiation (right-to-left square-and-multiply) built on
// a single MSB-first interleaved shift-add modular multiplier.
module mod_exp #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             ready_in,
  input  logic [WIDTH-1:0] base_in,
  input  logic [WIDTH-1:0] exp_in,
  input  logic [WIDTH-1:0] modulus_in,
  output logic [WIDTH-1:0] value_out,
  output logic             busy_out,
  output logic             valid_out,
  output logic [2:0]       state_dbg_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REDUCE = 3'd1,
    MUL    = 3'd2,
    SQR    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             busy_q, busy_d;
  logic             busy_dly_q, busy_dly_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // One multiplier step: double-and-reduce, then conditional add-and-reduce.
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   dbl, dbl_r, add, add_r;
  logic [WIDTH-1:0] product;
  logic             last_step;

  assign m_ext     = {1'b0, mod_q};
  assign dbl       = acc_q << 1;
  assign dbl_r     = (dbl >= m_ext) ? (dbl - m_ext) : dbl;
  assign add       = a_q[WIDTH-1] ? (dbl_r + {1'b0, b_q}) : dbl_r;
  assign add_r     = (add >= m_ext) ? (add - m_ext) : add;
  assign product   = add_r[WIDTH-1:0];
  assign last_step = (cnt_q == CNT_LAST);

  logic             decide;
  logic [WIDTH-1:0] e_view;
  logic [WIDTH-1:0] b_view;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    exp_d      = exp_q;
    mod_d      = mod_q;
    result_d   = result_q;
    value_d    = value_q;
    busy_d     = busy_q;
    busy_dly_d = busy_q;
    acc_d      = acc_q;
    a_d        = a_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    decide     = 1'b0;
    e_view     = exp_q;
    b_view     = product;

    case (state_q)
      IDLE: begin
        if (ready_in) begin
          base_d = base_in;
          exp_d  = exp_in;
          mod_d  = modulus_in;
          busy_d = 1'b1;
          acc_d  = '0;
          cnt_d  = '0;
          if ((modulus_in < WIDTH'(2)) || (exp_in == '0)) begin
            state_d  = DONE;
            result_d = (modulus_in < WIDTH'(2)) ? '0 : WIDTH'(1);
          end else begin
            // base * 1 through the multiplier yields base mod m
            state_d  = REDUCE;
            result_d = WIDTH'(1);
            a_d      = base_in;
            b_d      = WIDTH'(1);
          end
        end
      end

      REDUCE, MUL, SQR: begin
        acc_d = add_r;
        a_d   = a_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (last_step) begin
          acc_d = '0;
          cnt_d = '0;
          if (state_q == REDUCE) begin
            base_d = product;
            decide = 1'b1;
          end else if (state_q == SQR) begin
            base_d = product;
            exp_d  = exp_q >> 1;
            e_view = exp_q >> 1;
            decide = 1'b1;
          end else begin
            result_d = product;
            if (|exp_q[WIDTH-1:1]) begin
              state_d = SQR;
              a_d     = base_q;
              b_d     = base_q;
            end else begin
              state_d = DONE;
            end
          end
        end
      end

      DONE: begin
        value_d = result_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    // Next step after the working base has just been (re)computed.
    if (decide) begin
      if (e_view[0]) begin
        state_d = MUL;
        a_d     = result_q;
        b_d     = b_view;
      end else if (|e_view[WIDTH-1:1]) begin
        state_d = SQR;
        a_d     = b_view;
        b_d     = b_view;
      end else begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      base_q     <= '0;
      exp_q      <= '0;
      mod_q      <= '0;
      result_q   <= '0;
      value_q    <= '0;
      busy_q     <= 1'b0;
      busy_dly_q <= 1'b0;
      acc_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      exp_q      <= exp_d;
      mod_q      <= mod_d;
      result_q   <= result_d;
      value_q    <= value_d;
      busy_q     <= busy_d;
      busy_dly_q <= busy_dly_d;
      acc_q      <= acc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
    end
  end

  assign value_out     = value_q;
  assign busy_out      = busy_q;
  assign valid_out     = busy_dly_q & ~busy_q;
  assign state_dbg_out = state_q;

endmodule

// File: tb/tb_mod_exp.sv
// Self-checking bench for mod_exp: directed cases, reset abort, back-to-back
// starts and randomized operands against a plain-arithmetic reference.
module tb_mod_exp;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         ready;
  logic [W-1:0] base, expo, modv;
  logic [W-1:0] value;
  logic         busy, valid;
  logic [2:0]   state_dbg;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  mod_exp #(.WIDTH(W)) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .ready_in      (ready),
    .base_in       (base),
    .exp_in        (expo),
    .modulus_in    (modv),
    .value_out     (value),
    .busy_out      (busy),
    .valid_out     (valid),
    .state_dbg_out (state_dbg)
  );

  function automatic logic [W-1:0] ref_val(input logic [W-1:0] b, input logic [W-1:0] e,
                                           input logic [W-1:0] m);
    longint r, bb;
    if (m < 2) return '0;
    r  = 1;
    bb = longint'(b) % longint'(m);
    for (int i = 0; i < int'(e); i++) r = (r * bb) % longint'(m);
    return W'(r);
  endfunction

  function automatic int ref_busy(input logic [W-1:0] e, input logic [W-1:0] m);
    int lg;
    if (m < 2 || e == 0) return 1;
    lg = 0;
    for (int i = 0; i < W; i++) if (e[i]) lg = i;
    return W * (1 + $countones(e) + lg) + 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Start one operation and follow it to completion; optionally disturb inputs while busy.
  task automatic run_op(input string tag, input logic [W-1:0] b, input logic [W-1:0] e,
                        input logic [W-1:0] m, input logic [W-1:0] want_val,
                        input int want_busy, input bit scramble);
    int cycles, stray, guard;
    @(negedge clk);
    base = b; expo = e; modv = m; ready = 1'b1;
    exp_q.push_back(want_val);
    @(negedge clk);
    ready = 1'b0;
    cycles = 0; stray = 0; guard = 0;
    while (busy === 1'b1 && guard < 4000) begin
      cycles++;
      if (valid !== 1'b0) stray++;
      if (scramble) begin
        base  = W'($urandom);
        expo  = W'($urandom);
        modv  = W'($urandom);
        ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      guard++;
    end
    ready = 1'b0;
    check({tag, "_timeout"}, 32'(busy), 32'd0);
    check({tag, "_busy_cycles"}, 32'(cycles), 32'(want_busy));
    check({tag, "_stray_valid"}, 32'(stray), 32'd0);
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_value"}, 32'(value), 32'(exp_q.pop_front()));
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(valid), 32'd0);
    check({tag, "_value_hold"}, 32'(value), 32'(want_val));
  endtask

  initial begin
    int vcount, bcount, cycles, guard;
    logic [W-1:0] rb, re, rm;
    rst = 1'b0; ready = 1'b0; base = '0; expo = '0; modv = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_value", 32'(value), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // directed cases
    run_op("ex_4_13_497", 16'd4, 16'd13, 16'd497, 16'd445, 113, 1'b0);
    run_op("ex_10_3_7", 16'd10, 16'd3, 16'd7, 16'd6, 65, 1'b0);
    run_op("ex_exp0", 16'd3, 16'd0, 16'd7, 16'd1, 1, 1'b0);
    run_op("ex_mod1", 16'd9, 16'd5, 16'd1, 16'd0, 1, 1'b0);
    run_op("ex_max", 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFE, 513, 1'b1);
    run_op("ex_mod0", 16'd5, 16'd7, 16'd0, 16'd0, 1, 1'b0);
    run_op("ex_mod2", 16'd3, 16'd1, 16'd2, 16'd1, 33, 1'b0);

    // reset 20 cycles into an operation, with ready held during reset
    @(negedge clk);
    base = 16'd4; expo = 16'd13; modv = 16'd497; ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    repeat (19) @(negedge clk);
    check("abort_mid_busy", 32'(busy), 32'd1);
    rst = 1'b0; ready = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(valid), 32'd0);
    check("abort_value", 32'(value), 32'd0);
    @(negedge clk);
    check("abort_no_accept", 32'(busy), 32'd0);
    ready = 1'b0; rst = 1'b1;
    vcount = 0; bcount = 0;
    repeat (150) begin
      @(negedge clk);
      if (valid !== 1'b0) vcount++;
      if (busy !== 1'b0) bcount++;
    end
    check("abort_after_valid", 32'(vcount), 32'd0);
    check("abort_after_busy", 32'(bcount), 32'd0);
    run_op("post_abort", 16'd10, 16'd3, 16'd7, 16'd6, 65, 1'b0);

    // back-to-back with ready held high
    @(negedge clk);
    base = 16'd10; expo = 16'd3; modv = 16'd7; ready = 1'b1;
    @(negedge clk);
    cycles = 0; guard = 0;
    while (busy === 1'b1 && guard < 4000) begin
      cycles++; guard++;
      @(negedge clk);
    end
    check("b2b_first_busy", 32'(cycles), 32'd65);
    check("b2b_first_valid", 32'(valid), 32'd1);
    check("b2b_first_value", 32'(value), 32'd6);
    base = 16'd4; expo = 16'd13; modv = 16'd497;
    @(negedge clk);
    check("b2b_gap", 32'(busy), 32'd1);
    check("b2b_valid_low", 32'(valid), 32'd0);
    ready = 1'b0;
    cycles = 0; guard = 0;
    while (busy === 1'b1 && guard < 4000) begin
      cycles++; guard++;
      @(negedge clk);
    end
    check("b2b_second_busy", 32'(cycles), 32'd113);
    check("b2b_second_valid", 32'(valid), 32'd1);
    check("b2b_second_value", 32'(value), 32'd445);

    // randomized operands against the reference
    for (int i = 0; i < 20; i++) begin
      rb = W'($urandom);
      rm = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      re = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
      run_op($sformatf("rand%0d", i), rb, re, rm, ref_val(rb, re, rm), ref_busy(re, rm),
             1'(i % 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
